mult_sched: RTL and testbench
=============================

MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, level; held until gnt0.
REQ-005 a0  input  WIDTH  requester 0 multiplicand; valid while req0 is high.
REQ-006 b0  input  WIDTH  requester 0 multiplier; valid while req0 is high.
REQ-007 req1, a1, b1: same as req0, a0, b0, for requester 1.
REQ-008 gnt0  output  1  one-cycle pulse; requester 0 operands captured this cycle.
REQ-009 gnt1  output  1  one-cycle pulse; requester 1 operands captured this cycle.
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done  output  1  one-cycle pulse; product valid.
REQ-012 done_id  output  1  requester owning the current product.
REQ-013 product  output  2*WIDTH  unsigned a*b; held until the next done.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with the datapath shared by both requesters.
REQ-015 In IDLE with any req high, the block SHALL grant exactly one requester, capture its a and b, clear the accumulator and the count, and move to RUN.
- gnt asserted combinationally in that same cycle.
REQ-016 Arbitration SHALL be round-robin.
- Single requester: that requester wins.
- Both requesting: the requester other than last_id wins.
- last_id updates on every grant.
REQ-017 RUN, each cycle: if multiplier LSB=1 then acc += multiplicand; multiplicand <<= 1 (2*WIDTH-bit register); multiplier >>= 1; count++.
REQ-018 RUN SHALL last exactly WIDTH cycles, then go to DONE; the accumulator SHALL never overflow 2*WIDTH bits.
REQ-019 In DONE, the block SHALL load product from acc, set done_id, pulse done for one cycle, and return to IDLE.
REQ-020 Latency: done SHALL be asserted WIDTH+1 cycles after the gnt cycle; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-021 req inputs during RUN/DONE SHALL be ignored (no gnt), and requests still pending SHALL be served in the next IDLE cycle.
REQ-022 A requester holding req high after gnt SHALL be treated as a new request.
REQ-023 gnt0 and gnt1 SHALL be mutually exclusive, and done and gnt SHALL never be asserted in the same cycle.

Reset
REQ-024 rst SHALL force the following, regardless of state, including mid-RUN: state=IDLE; gnt0, gnt1, busy, done, done_id = 0; product=0; acc=0; count=0; last_id=1 (requester 0 wins first tie).
REQ-025 An operation aborted by rst SHALL never produce done.

Configuration
REQ-026 Macro MULT_SCHED_EARLY_EXIT_EN defined: RUN SHALL exit to DONE at the end of the first cycle in which the shifted multiplier is zero or count reaches WIDTH-1.
- Minimum one RUN cycle; done at gnt+k+1, where k = RUN cycles.
REQ-027 Macro not defined: RUN SHALL always last WIDTH cycles per REQ-018; results SHALL be identical in both modes.

Structure
REQ-028 Shared package mult_pkg SHALL hold the WIDTH default and the FSM state encoding type/constants (IDLE, RUN, DONE).
REQ-029 Sub-module mult_datapath SHALL hold the multiplicand/multiplier shift registers, accumulator and counter, driven by load/step controls from the mult_sched FSM.

Verification
REQ-030 Single request: after rst, req0 with a0=3, b0=5 -> gnt0 in first IDLE cycle; done 9 cycles later (macro off); product=15; done_id=0.
REQ-031 Maximum operands: a0=255, b0=255 -> product=65025 (0xFE01), no overflow.
REQ-032 Tie: req0 (2,3) and req1 (4,5) both held from reset.
- gnt0 first -> product 6, done_id 0.
- Then gnt1 -> product 20, done_id 1.
- Next tie goes to requester 0.
REQ-033 Busy handling: req1 raised mid-RUN -> no gnt1 until IDLE.
- rst at RUN cycle 4 -> busy=0 and done=0 next cycle; product=0.
REQ-034 Early exit: b0=1, a0=200, macro on -> done 2 cycles after gnt, product 200; macro off -> 9 cycles.
- b0=0 -> product 0 in both modes.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the mult_sched shift-and-add multiplier scheduler.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-and-add datapath: multiplicand/multiplier shifters, accumulator and step counter.
// Build option MULT_SCHED_EARLY_EXIT_EN ends the run once the remaining multiplier is zero.
import mult_pkg::*;

module mult_datapath #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;

  // Next accumulator value and end-of-run detection for the current step
  always_comb begin
    addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
    acc_next = acc_r + addend_s;
`ifdef MULT_SCHED_EARLY_EXIT_EN
    last = (count_r == CW'(WIDTH - 1)) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    last = (count_r == CW'(WIDTH - 1));
`endif
  end

  // Operand capture on load, one shift-and-add iteration per step
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (load) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= b;
      count_r  <= {CW{1'b0}};
    end else if (step) begin
      acc_r    <= acc_next;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      count_r  <= count_r + CW'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      count_r  <= count_r;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Two-requester round-robin scheduler sharing one shift-and-add multiplier.
// Build option MULT_SCHED_EARLY_EXIT_EN (see mult_datapath) shortens runs for small multipliers.
import mult_pkg::*;

module mult_sched #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  state_t               state_r;
  state_t               state_next_s;
  logic                 last_id_r;
  logic                 cur_id_r;
  logic                 done_id_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 pick_s;
  logic                 grant_s;
  logic [WIDTH-1:0]     a_sel_s;
  logic [WIDTH-1:0]     b_sel_s;
  logic                 step_s;
  logic                 last_step_s;
  logic [2*WIDTH-1:0]   acc_next_s;

  // Round-robin pick: on a tie the requester that was not served last wins
  always_comb begin
    pick_s = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_id_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    grant_s = (state_r == IDLE) && (req0 || req1) && !rst;
    a_sel_s = pick_s ? a1 : a0;
    b_sel_s = pick_s ? b1 : b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = grant_s ? RUN : IDLE;
      RUN:     state_next_s = last_step_s ? DONE : RUN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode; rst suppresses every strobe in the cycle it is applied
  always_comb begin
    gnt0   = grant_s && !pick_s;
    gnt1   = grant_s && pick_s;
    busy   = !rst && ((state_r == RUN) || (state_r == DONE));
    done   = !rst && (state_r == DONE);
    step_s = !rst && (state_r == RUN);
  end

  // Owner tracking and result capture; the final sum lands as DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_r <= 1'b1;
      cur_id_r  <= 1'b0;
      done_id_r <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      if (grant_s) begin
        last_id_r <= pick_s;
        cur_id_r  <= pick_s;
      end else begin
        last_id_r <= last_id_r;
        cur_id_r  <= cur_id_r;
      end
      if (step_s && last_step_s) begin
        product_r <= acc_next_s;
        done_id_r <= cur_id_r;
      end else begin
        product_r <= product_r;
        done_id_r <= done_id_r;
      end
    end
  end

  assign product = product_r;
  assign done_id = done_id_r;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_s),
    .step     (step_s),
    .a        (a_sel_s),
    .b        (b_sel_s),
    .acc_next (acc_next_s),
    .last     (last_step_s)
  );

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed scenarios with literal expectations
// plus randomized two-requester traffic checked against a transaction-level model.
module tb_mult_sched;

  localparam int W = 8;

`ifdef MULT_SCHED_EARLY_EXIT_EN
  localparam int LAT_3X5   = 4;
  localparam int LAT_B1    = 2;
  localparam int LAT_B0    = 2;
`else
  localparam int LAT_3X5   = 9;
  localparam int LAT_B1    = 9;
  localparam int LAT_B0    = 9;
`endif
  localparam int LAT_FULL = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, busy, done, done_id;
  logic [2*W-1:0] product;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int             m_left = 0;
  logic           m_last = 1'b1;
  logic           m_owner = 1'b0;
  logic [15:0]    m_a = 16'd0, m_b = 16'd0;
  logic [15:0]    m_prod = 16'd0;
  logic           m_id = 1'b0;

  always #5 clk = ~clk;

  mult_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .product(product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // number of RUN cycles an operation with multiplier b takes
  function automatic int run_len(input logic [W-1:0] b);
`ifdef MULT_SCHED_EARLY_EXIT_EN
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return (n == 0) ? 1 : n;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'hFF;
      2:       return 8'd1;
      3:       return 8'(1 << $urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, outputs versus the transaction model
  initial begin : compare
    logic e_g0, e_g1, e_busy, e_done, w;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_done", 32'(done), 0);
        m_left = 0; m_last = 1'b1; m_prod = 16'd0; m_id = 1'b0;
      end else begin
        e_g0 = 1'b0; e_g1 = 1'b0; e_done = 1'b0;
        if (m_left == 0) begin
          e_busy = 1'b0;
          if (req0 || req1) begin
            w = (req0 && req1) ? !m_last : !req0;
            if (w) begin e_g1 = 1'b1; m_a = 16'(a1); m_b = 16'(b1); end
            else   begin e_g0 = 1'b1; m_a = 16'(a0); m_b = 16'(b0); end
            m_owner = w;
            m_last  = w;
            m_left  = run_len(w ? b1 : b0) + 1;
          end
        end else begin
          e_busy = 1'b1;
          if (m_left == 1) begin
            e_done = 1'b1;
            m_prod = m_a * m_b;
            m_id   = m_owner;
          end
          m_left = m_left - 1;
        end
        check("gnt0", 32'(gnt0), 32'(e_g0));
        check("gnt1", 32'(gnt1), 32'(e_g1));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("product", 32'(product), 32'(m_prod));
        check("done_id", 32'(done_id), 32'(m_id));
      end
    end
  end

  // From posedge+1 of the cycle after a grant, count cycles until done
  task automatic wait_done(input int limit, output int lat);
    lat = 1;
    @(negedge clk);
    while (!done && lat < limit) begin
      tick();
      lat++;
      @(negedge clk);
    end
  endtask

  // Single requester-0 operation starting in an IDLE cycle
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int exp_lat, input logic [15:0] exp_prod, input string nm);
    int lat;
    req0 = 1'b1; a0 = a; b0 = b;
    @(negedge clk);
    check({nm, "_gnt0"}, 32'(gnt0), 1);
    tick();
    req0 = 1'b0;
    wait_done(40, lat);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_product"}, 32'(product), 32'(exp_prod));
    check({nm, "_done_id"}, 32'(done_id), 0);
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  lat;
    logic g0, g1, seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
    tick(); tick();
    rst = 1'b0;

    run_single(8'd3,   8'd5,   LAT_3X5,  16'd15,    "single_3x5");
    run_single(8'd255, 8'd255, LAT_FULL, 16'hFE01,  "max_255x255");
    run_single(8'd200, 8'd1,   LAT_B1,   16'd200,   "early_b1");
    run_single(8'd200, 8'd0,   LAT_B0,   16'd0,     "early_b0");

    // Tie with both requests held from reset
    rst = 1'b1;
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
    req1 = 1'b1; a1 = 8'd4; b1 = 8'd5;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("tie_first_gnt0", 32'(gnt0), 1);
    check("tie_first_gnt1", 32'(gnt1), 0);
    tick();
    wait_done(40, lat);
    check("tie_prod_6", 32'(product), 6);
    check("tie_id_0", 32'(done_id), 0);
    tick();
    @(negedge clk);
    check("tie_second_gnt1", 32'(gnt1), 1);
    tick();
    wait_done(40, lat);
    check("tie_prod_20", 32'(product), 20);
    check("tie_id_1", 32'(done_id), 1);
    tick();
    @(negedge clk);
    check("tie_third_gnt0", 32'(gnt0), 1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    wait_done(40, lat);
    tick();

    // Request during RUN is held off, then rst aborts in RUN cycle 4
    req0 = 1'b1; a0 = 8'd7; b0 = 8'd255;
    @(negedge clk);
    check("abort_gnt0", 32'(gnt0), 1);
    tick();
    req0 = 1'b0; req1 = 1'b1; a1 = 8'd9; b1 = 8'd9;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("busy_no_gnt1", 32'(gnt1), 0);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_product", 32'(product), 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    tick();

    // Randomized traffic: requests held until granted, occasional rst
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (req0 && g0) begin
        req0 = 1'($urandom_range(0, 1)); a0 = rnd_op(); b0 = rnd_op();
      end else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; a0 = rnd_op(); b0 = rnd_op();
      end
      if (req1 && g1) begin
        req1 = 1'($urandom_range(0, 1)); a1 = rnd_op(); b1 = rnd_op();
      end else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; a1 = rnd_op(); b1 = rnd_op();
      end
    end

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
